// File: rtl/online_addsub_seq_r4.sv
// Digit-serial radix-4 online adder/subtractor, MSD first, online delay 1; done N+1 edges after accept.
// No backpressure: start is taken only in IDLE. Optional digit stream under `ONLINE_SEQ_STREAM_EN.
module online_addsub_seq_r4 #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sub,
    input  logic [3*N-1:0]     x_vec,
    input  logic [3*N-1:0]     y_vec,
    output logic               busy,
    output logic               done,
    output logic [3*(N+1)-1:0] z_vec,
    output logic               err,
    output logic [2:0]         z_digit,
    output logic               z_valid
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam int CW = $clog2(N + 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [3*N-1:0]     xs, ys;
    logic               sub_q;
    logic signed [2:0]  w_q;

    logic [2:0]         x_msd, y_msd;
    logic               x_bad, y_bad;
    logic signed [3:0]  xd, yd, s;
    logic signed [2:0]  t, w_nxt, t_eff, z_new;

    // Code 100 (-4) is illegal; it is flagged and contributes zero.
    always_comb begin
        x_msd = xs[3*N-1 -: 3];
        y_msd = ys[3*N-1 -: 3];
        x_bad = (x_msd == 3'b100);
        y_bad = (y_msd == 3'b100);
        xd    = x_bad ? 4'sd0 : $signed({x_msd[2], x_msd});
        yd    = y_bad ? 4'sd0 : $signed({y_msd[2], y_msd});
        s     = sub_q ? (xd - yd) : (xd + yd);
        if (s >= 4'sd3)
            t = 3'sd1;
        else if (s <= -4'sd3)
            t = -3'sd1;
        else
            t = 3'sd0;
        // s - 4t modulo 8 is just a flip of bit 2 whenever a transfer occurs.
        w_nxt = $signed({s[2] ^ (t != 3'sd0), s[1:0]});
        t_eff = (state == FLUSH) ? 3'sd0 : t;
        z_new = w_q + t_eff;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(N - 1)) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FLUSH);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            xs    <= '0;
            ys    <= '0;
            sub_q <= 1'b0;
            w_q   <= '0;
            err   <= 1'b0;
            z_vec <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        xs    <= x_vec;
                        ys    <= y_vec;
                        sub_q <= sub;
                        cnt   <= '0;
                        w_q   <= '0;
                        err   <= 1'b0;
                        z_vec <= '0;
                    end
                end
                RUN: begin
                    xs    <= {xs[3*N-4:0], 3'b000};
                    ys    <= {ys[3*N-4:0], 3'b000};
                    cnt   <= cnt + 1'b1;
                    w_q   <= w_nxt;
                    err   <= err | x_bad | y_bad;
                    z_vec <= {z_vec[3*N-1:0], z_new};
                end
                FLUSH: begin
                    w_q   <= '0;
                    z_vec <= {z_vec[3*N-1:0], z_new};
                end
                default: ;
            endcase
        end
    end

`ifdef ONLINE_SEQ_STREAM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            z_valid <= 1'b0;
            z_digit <= 3'b000;
        end else begin
            z_valid <= busy;
            z_digit <= busy ? z_new : 3'b000;
        end
    end
`else
    assign z_valid = 1'b0;
    assign z_digit = 3'b000;
`endif

endmodule

// File: tb/tb_online_addsub_seq_r4.sv
// Directed-vector bench for online_addsub_seq_r4 with N=4.
module tb_online_addsub_seq_r4;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic [11:0] x_vec;
    logic [11:0] y_vec;
    logic        busy;
    logic        done;
    logic [14:0] z_vec;
    logic        err;
    logic [2:0]  z_digit;
    logic        z_valid;

    int checks = 0;
    int errors = 0;

    online_addsub_seq_r4 #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sub     (sub),
        .x_vec   (x_vec),
        .y_vec   (y_vec),
        .busy    (busy),
        .done    (done),
        .z_vec   (z_vec),
        .err     (err),
        .z_digit (z_digit),
        .z_valid (z_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pk4(input int a, input int b, input int c, input int d);
        return {a[2:0], b[2:0], c[2:0], d[2:0]};
    endfunction

    function automatic logic [14:0] pk5(input int a, input int b, input int c, input int d, input int e);
        return {a[2:0], b[2:0], c[2:0], d[2:0], e[2:0]};
    endfunction

    // Accept edge is edge 1; done must be visible after edge N+2.
    task automatic run_op(input string tag, input logic s, input logic [11:0] xv, input logic [11:0] yv,
                          input logic [14:0] zexp, input logic eexp, input logic hold);
        int          e;
        int          ndig;
        logic [14:0] sacc;
        logic        got_done;
        logic        any_stream;
        e = 1; ndig = 0; sacc = '0; got_done = 1'b0; any_stream = 1'b0;
        @(negedge clk);
        start = 1'b1; sub = s; x_vec = xv; y_vec = yv;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        for (int k = 0; k < 20; k++) begin
            if (z_valid) begin
                sacc = {sacc[11:0], z_digit};
                ndig++;
            end
            if (z_valid || z_digit != 3'b000) any_stream = 1'b1;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check({tag, "_done_edge"}, 32'(e), 32'(N + 2));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_z_vec"}, 32'(z_vec), 32'(zexp));
        check({tag, "_err"}, 32'(err), 32'(eexp));
`ifdef ONLINE_SEQ_STREAM_EN
        check({tag, "_stream_count"}, 32'(ndig), 32'd5);
        check({tag, "_stream_digits"}, 32'(sacc), 32'(zexp));
`else
        check({tag, "_stream_quiet"}, 32'(any_stream), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_not_busy"}, 32'(busy), 32'd0);
        check({tag, "_z_hold"}, 32'(z_vec), 32'(zexp));
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check({tag, "_second_accept"}, 32'(busy), 32'd1);
            got_done = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (done) begin
                    got_done = 1'b1;
                    break;
                end
                @(posedge clk);
                @(negedge clk);
            end
            check({tag, "_second_done"}, 32'(got_done), 32'd1);
            check({tag, "_second_z"}, 32'(z_vec), 32'(zexp));
        end
    endtask

    initial begin
        int done_cnt;
        reset = 1'b1; start = 1'b0; sub = 1'b0; x_vec = '0; y_vec = '0;
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_z_vec", 32'(z_vec), 32'd0);
        check("rst_z_valid", 32'(z_valid), 32'd0);
        check("rst_z_digit", 32'(z_digit), 32'd0);
        start = 1'b0;
        reset = 1'b0;

        run_op("add107", 1'b0, pk4(1, 2, 3, -1), pk4(0, 0, 0, 0), pk5(0, 1, 3, -1, -1), 1'b0, 1'b0);
        run_op("add510", 1'b0, pk4(3, 3, 3, 3), pk4(3, 3, 3, 3), pk5(1, 3, 3, 3, 2), 1'b0, 1'b0);
        run_op("sub_m510", 1'b1, pk4(-3, -3, -3, -3), pk4(3, 3, 3, 3), pk5(-1, -3, -3, -3, -2), 1'b0, 1'b0);
        run_op("sub_hold", 1'b1, pk4(0, 0, 0, 1), pk4(0, 0, 0, 3), pk5(0, 0, 0, 0, -2), 1'b0, 1'b1);
        run_op("x_illegal", 1'b0, pk4(1, -4, 3, -1), pk4(0, 0, 0, 0), pk5(0, 1, 1, -1, -1), 1'b1, 1'b0);
        run_op("err_clear", 1'b0, pk4(1, 2, 3, -1), pk4(0, 0, 0, 0), pk5(0, 1, 3, -1, -1), 1'b0, 1'b0);
        run_op("y_illegal", 1'b1, pk4(0, 0, 0, 0), pk4(0, 0, -4, 2), pk5(0, 0, 0, 0, -2), 1'b1, 1'b0);

        // Abort in the second RUN cycle.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; x_vec = pk4(3, 3, 3, 3); y_vec = pk4(3, 3, 3, 3);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_z_vec", 32'(z_vec), 32'd0);
        check("abort_z_valid", 32'(z_valid), 32'd0);
        check("abort_z_digit", 32'(z_digit), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
